// File: rtl/dcp_way_partitioner.sv
// Two-domain way-partition controller: counts misses per domain over fixed epochs
// and moves one way per epoch toward the hungrier domain, flushing it first.
module dcp_way_partitioner #(
  parameter int NUM_WAYS  = 8,
  parameter int EPOCH_LEN = 256,
  parameter int CNT_W     = 16,
  parameter int MIN_WAYS  = 1,
  parameter int HYST      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic                        req_domain,
  input  logic                        req_hit,
  output logic [NUM_WAYS-1:0]         way_mask_d0,
  output logic [NUM_WAYS-1:0]         way_mask_d1,
  output logic [$clog2(NUM_WAYS):0]   boundary,
  output logic                        flush_valid,
  output logic [$clog2(NUM_WAYS)-1:0] flush_way,
  input  logic                        flush_ready,
  output logic                        busy
);
  localparam int WW = $clog2(NUM_WAYS);
  localparam int BW = WW + 1;
  localparam int EW = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;

  localparam logic [1:0] ST_COUNT  = 2'd0;
  localparam logic [1:0] ST_DECIDE = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;

  localparam logic [CNT_W-1:0]    CNT_MAX   = '1;
  localparam logic [CNT_W:0]      HYST_V    = (CNT_W+1)'(HYST);
  localparam logic [BW-1:0]       B_MIN     = BW'(MIN_WAYS);
  localparam logic [BW-1:0]       B_MAX     = BW'(NUM_WAYS - MIN_WAYS);
  localparam logic [BW-1:0]       B_RST     = BW'(NUM_WAYS / 2);
  localparam logic [EW-1:0]       EP_LAST   = EW'(EPOCH_LEN - 1);
  localparam logic [NUM_WAYS-1:0] MASK0_RST = {{(NUM_WAYS/2){1'b0}}, {(NUM_WAYS/2){1'b1}}};

  logic [1:0]          state_q, state_d;
  logic [EW-1:0]       epoch_q, epoch_d;
  logic [CNT_W-1:0]    miss0_q, miss0_d, miss1_q, miss1_d;
  logic [CNT_W-1:0]    snap0_q, snap0_d, snap1_q, snap1_d;
  logic [CNT_W-1:0]    miss0_live, miss1_live;
  logic [BW-1:0]       b_q, b_d;
  logic                dir_q, dir_d;
  logic                fvalid_q, fvalid_d;
  logic [WW-1:0]       fway_q, fway_d;
  logic [NUM_WAYS-1:0] mask0_q, mask0_d, mask1_q, mask1_d;
  logic                busy_q, busy_d;
  logic                is_miss;

  always_comb begin
    is_miss    = req_valid && !req_hit;
    miss0_live = miss0_q;
    miss1_live = miss1_q;
    if (is_miss && !req_domain && miss0_q != CNT_MAX) miss0_live = miss0_q + 1'b1;
    if (is_miss &&  req_domain && miss1_q != CNT_MAX) miss1_live = miss1_q + 1'b1;

    state_d  = state_q;
    epoch_d  = epoch_q;
    miss0_d  = miss0_live;
    miss1_d  = miss1_live;
    snap0_d  = snap0_q;
    snap1_d  = snap1_q;
    b_d      = b_q;
    dir_d    = dir_q;
    fvalid_d = fvalid_q;
    fway_d   = fway_q;

    case (state_q)
      ST_COUNT: begin
        if (epoch_q == EP_LAST) begin
          // the final cycle's miss belongs to the closing epoch, not the next one
          snap0_d = miss0_live;
          snap1_d = miss1_live;
          miss0_d = '0;
          miss1_d = '0;
          epoch_d = '0;
          state_d = ST_DECIDE;
        end else begin
          epoch_d = epoch_q + 1'b1;
        end
      end
      ST_DECIDE: begin
        if (({1'b0, snap1_q} > ({1'b0, snap0_q} + HYST_V)) && (b_q > B_MIN)) begin
          dir_d    = 1'b1;
          fway_d   = WW'(b_q - 1'b1);
          fvalid_d = 1'b1;
          state_d  = ST_FLUSH;
        end else if (({1'b0, snap0_q} > ({1'b0, snap1_q} + HYST_V)) && (b_q < B_MAX)) begin
          dir_d    = 1'b0;
          fway_d   = b_q[WW-1:0];
          fvalid_d = 1'b1;
          state_d  = ST_FLUSH;
        end else begin
          state_d  = ST_COUNT;
        end
      end
      ST_FLUSH: begin
        if (fvalid_q && flush_ready) begin
          b_d      = dir_q ? (b_q - 1'b1) : (b_q + 1'b1);
          fvalid_d = 1'b0;
          state_d  = ST_COUNT;
        end
      end
      default: state_d = ST_COUNT;
    endcase

    busy_d = (state_d != ST_COUNT);
  end

  // The moving way is withheld from both domains while it is being flushed.
  for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_mask
    logic hole;
    assign hole        = (state_d == ST_FLUSH) && (fway_d == WW'(gi));
    assign mask0_d[gi] = (BW'(gi) <  b_d) && !hole;
    assign mask1_d[gi] = (BW'(gi) >= b_d) && !hole;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_COUNT;
      epoch_q  <= '0;
      miss0_q  <= '0;
      miss1_q  <= '0;
      snap0_q  <= '0;
      snap1_q  <= '0;
      b_q      <= B_RST;
      dir_q    <= 1'b0;
      fvalid_q <= 1'b0;
      fway_q   <= '0;
      mask0_q  <= MASK0_RST;
      mask1_q  <= ~MASK0_RST;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      epoch_q  <= epoch_d;
      miss0_q  <= miss0_d;
      miss1_q  <= miss1_d;
      snap0_q  <= snap0_d;
      snap1_q  <= snap1_d;
      b_q      <= b_d;
      dir_q    <= dir_d;
      fvalid_q <= fvalid_d;
      fway_q   <= fway_d;
      mask0_q  <= mask0_d;
      mask1_q  <= mask1_d;
      busy_q   <= busy_d;
    end
  end

  assign way_mask_d0 = mask0_q;
  assign way_mask_d1 = mask1_q;
  assign boundary    = b_q;
  assign flush_valid = fvalid_q;
  assign flush_way   = fway_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_dcp_way_partitioner.sv
// Randomized bench for dcp_way_partitioner against an epoch-level reference model;
// a second instance with 4-bit counters covers counter saturation.
module tb_dcp_way_partitioner;
  localparam int NW   = 8;
  localparam int MINW = 1;
  localparam int HY   = 4;
  localparam int PH_COUNT  = 0;
  localparam int PH_DECIDE = 1;
  localparam int PH_FLUSH  = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_domain = 1'b0, req_hit = 1'b0, flush_ready = 1'b0;
  logic sel = 1'b0;

  logic [7:0] a_m0, a_m1, b_m0, b_m1, o_m0, o_m1;
  logic [3:0] a_bd, b_bd, o_bd;
  logic [2:0] a_fw, b_fw, o_fw;
  logic       a_fv, b_fv, o_fv, a_busy, b_busy, o_busy;

  always #5 clk = ~clk;

  dcp_way_partitioner #(.NUM_WAYS(8), .EPOCH_LEN(256), .CNT_W(16), .MIN_WAYS(1), .HYST(4)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_domain(req_domain), .req_hit(req_hit),
    .way_mask_d0(a_m0), .way_mask_d1(a_m1), .boundary(a_bd), .flush_valid(a_fv),
    .flush_way(a_fw), .flush_ready(flush_ready), .busy(a_busy));

  dcp_way_partitioner #(.NUM_WAYS(8), .EPOCH_LEN(64), .CNT_W(4), .MIN_WAYS(1), .HYST(4)) u_sat (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_domain(req_domain), .req_hit(req_hit),
    .way_mask_d0(b_m0), .way_mask_d1(b_m1), .boundary(b_bd), .flush_valid(b_fv),
    .flush_way(b_fw), .flush_ready(flush_ready), .busy(b_busy));

  assign o_m0   = sel ? b_m0   : a_m0;
  assign o_m1   = sel ? b_m1   : a_m1;
  assign o_bd   = sel ? b_bd   : a_bd;
  assign o_fw   = sel ? b_fw   : a_fw;
  assign o_fv   = sel ? b_fv   : a_fv;
  assign o_busy = sel ? b_busy : a_busy;

  int total = 0;
  int bad   = 0;

  // reference model state (plain integers, epoch-level view)
  int m_b, m_phase, m_ep, m_acc0, m_acc1, m_s0, m_s1, m_fway, m_dir;
  int m_epoch_len, m_cnt_max;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int x);
    return (x > m_cnt_max) ? m_cnt_max : x;
  endfunction

  task automatic model_init();
    m_b = NW / 2; m_phase = PH_COUNT; m_ep = 0; m_acc0 = 0; m_acc1 = 0;
    m_s0 = 0; m_s1 = 0; m_fway = 0; m_dir = 0;
  endtask

  task automatic check_outputs();
    int lo, hole, e_fv, e_busy;
    lo     = (1 << m_b) - 1;
    hole   = (m_phase == PH_FLUSH) ? (1 << m_fway) : 0;
    e_fv   = (m_phase == PH_FLUSH) ? 1 : 0;
    e_busy = (m_phase != PH_COUNT) ? 1 : 0;
    chk("mask_d0",     32'(o_m0),   lo & ~hole & 255);
    chk("mask_d1",     32'(o_m1),   ~lo & ~hole & 255);
    chk("boundary",    32'(o_bd),   m_b);
    chk("flush_valid", 32'(o_fv),   e_fv);
    chk("busy",        32'(o_busy), e_busy);
    chk("flush_way",   32'(o_fw),   m_fway);
    chk("inv_disjoint", 32'(o_m0 & o_m1), 0);
    if (!o_fv) chk("inv_cover", 32'(o_m0 | o_m1), 255);
    chk("inv_range", (o_bd >= 4'(MINW) && o_bd <= 4'(NW - MINW)) ? 1 : 0, 1);
  endtask

  // Apply one cycle of inputs, advance the model, clock, compare.
  task automatic step(input logic v, input logic d, input logic h, input logic fr);
    int mi0, mi1;
    req_valid = v; req_domain = d; req_hit = h; flush_ready = fr;
    mi0 = (v && !h && !d) ? 1 : 0;
    mi1 = (v && !h &&  d) ? 1 : 0;
    m_acc0 += mi0;
    m_acc1 += mi1;
    if (m_phase == PH_COUNT) begin
      if (m_ep == m_epoch_len - 1) begin
        m_s0 = sat(m_acc0); m_s1 = sat(m_acc1);
        m_acc0 = 0; m_acc1 = 0; m_ep = 0;
        m_phase = PH_DECIDE;
      end else begin
        m_ep++;
      end
    end else if (m_phase == PH_DECIDE) begin
      if (m_s1 > m_s0 + HY && m_b > MINW) begin
        m_fway = m_b - 1; m_dir = -1; m_phase = PH_FLUSH;
      end else if (m_s0 > m_s1 + HY && m_b < NW - MINW) begin
        m_fway = m_b; m_dir = 1; m_phase = PH_FLUSH;
      end else begin
        m_phase = PH_COUNT;
      end
    end else if (fr) begin
      m_b += m_dir;
      m_phase = PH_COUNT;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0; req_valid = 1'b0; req_hit = 1'b0; req_domain = 1'b0; flush_ready = 1'b0;
    model_init();
    @(posedge clk);
    #1;
    chk("rst_mask_d0",     32'(o_m0), 32'h0F);
    chk("rst_mask_d1",     32'(o_m1), 32'hF0);
    chk("rst_boundary",    32'(o_bd), 4);
    chk("rst_flush_valid", 32'(o_fv), 0);
    chk("rst_busy",        32'(o_busy), 0);
    chk("rst_flush_way",   32'(o_fw), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One full epoch with n0/n1 misses placed at random COUNT cycles, then the
  // decision and any flush (optionally stalled, with misses during the stall).
  task automatic run_epoch(input int n0, input int n1, input int stall, input int stall_m0,
                           input bit rst_flush);
    int slots, r0, r1, left;
    logic v, d, h;
    while (m_phase != PH_COUNT) step(1'b0, 1'b0, 1'b0, 1'b1);
    slots = m_epoch_len - m_ep;
    r0 = n0; r1 = n1;
    for (int k = 0; k < slots; k++) begin
      left = slots - k;
      if (r0 + r1 > 0 && int'($urandom_range(0, left - 1)) < r0 + r1) begin
        v = 1'b1; h = 1'b0;
        if (int'($urandom_range(1, r0 + r1)) <= r0) begin d = 1'b0; r0--; end
        else begin d = 1'b1; r1--; end
      end else begin
        v = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); h = 1'b1;
      end
      step(v, d, h, 1'($urandom_range(0, 1)));
    end
    step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    if (m_phase == PH_FLUSH) begin
      for (int i = 0; i < stall; i++) step(i < stall_m0, 1'b0, 1'b0, 1'b0);
      if (rst_flush) begin
        #2;
        reset = 1'b0;
        #1;
        chk("rstflush_flush_valid", 32'(o_fv), 0);
        chk("rstflush_mask_d0",     32'(o_m0), 32'h0F);
        chk("rstflush_mask_d1",     32'(o_m1), 32'hF0);
        chk("rstflush_boundary",    32'(o_bd), 4);
        model_init();
        @(negedge clk);
        reset = 1'b1;
      end else begin
        step(1'b0, 1'b0, 1'b0, 1'b1);
      end
    end
  endtask

  initial begin
    m_epoch_len = 256; m_cnt_max = 65535; sel = 1'b0;
    do_reset();

    repeat (1000) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    chk("idle_boundary", 32'(o_bd), 4);

    run_epoch(0, 20, 0, 0, 1'b0);
    chk("d1heavy_boundary", 32'(o_bd), 3);
    chk("d1heavy_mask_d0",  32'(o_m0), 32'h07);
    chk("d1heavy_mask_d1",  32'(o_m1), 32'hF8);

    run_epoch(10, 14, 0, 0, 1'b0);
    chk("hyst_eq_boundary", 32'(o_bd), 3);
    run_epoch(10, 15, 0, 0, 1'b0);
    chk("hyst_over_boundary", 32'(o_bd), 2);

    repeat (3) run_epoch(0, 20, 0, 0, 1'b0);
    chk("floor_boundary", 32'(o_bd), 1);
    chk("floor_mask_d0",  32'(o_m0), 32'h01);
    chk("floor_mask_d1",  32'(o_m1), 32'hFE);

    repeat (8) run_epoch(20, 0, 0, 0, 1'b0);
    chk("ceil_boundary", 32'(o_bd), 7);
    chk("ceil_mask_d0",  32'(o_m0), 32'h7F);
    chk("ceil_mask_d1",  32'(o_m1), 32'h80);

    run_epoch(0, 20, 10, 8, 1'b0);
    chk("bp_boundary", 32'(o_bd), 6);
    run_epoch(0, 0, 0, 0, 1'b0);
    chk("bp_carry_boundary", 32'(o_bd), 7);

    repeat (8) run_epoch($urandom_range(0, 30), $urandom_range(0, 30),
                         $urandom_range(0, 4), $urandom_range(0, 2), 1'b0);

    run_epoch(20, 0, 0, 0, 1'b0);
    run_epoch(0, 25, 3, 0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);

    sel = 1'b1; m_epoch_len = 64; m_cnt_max = 15;
    do_reset();
    run_epoch(4, 40, 0, 0, 1'b0);
    chk("sat_boundary", 32'(o_bd), 3);
    run_epoch(12, 40, 0, 0, 1'b0);
    chk("sat_nomove_boundary", 32'(o_bd), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dcp_way_partitioner.md
# dcp_way_partitioner

Dynamic way-partition controller for a two-domain cache set. It sits directly upstream of the cacheline/PLRU replacement stage and drives per-domain allowed-way masks into it. It observes the per-access hit/miss stream, counts misses per security domain over fixed epochs, and moves one way across the partition boundary per epoch toward the domain with more misses. A moving way is flushed through a valid/ready handshake before it is handed over, so no way is ever visible to both domains.

## Interface
Parameters:
- NUM_WAYS, 8: ways per set; must be an even power of two ≥ 4.
- EPOCH_LEN, 256: COUNT-state cycles per epoch.
- CNT_W, 16: miss counter width; counters saturate.
- MIN_WAYS, 1: minimum ways each domain keeps.
- HYST, 4: miss difference that must be strictly exceeded before a way moves.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  a cache access completed this cycle.
- req_domain  in  1  domain of the access (0 or 1).
- req_hit  in  1  the access hit; a miss is req_valid && !req_hit.
- way_mask_d0  out  NUM_WAYS  ways domain 0 may allocate into.
- way_mask_d1  out  NUM_WAYS  ways domain 1 may allocate into.
- boundary  out  $clog2(NUM_WAYS)+1  domain 0 owns ways [0, boundary−1]; domain 1 owns the rest.
- flush_valid  out  1  request to invalidate/write back flush_way.
- flush_way  out  $clog2(NUM_WAYS)  way to flush.
- flush_ready  in  1  downstream accepts the flush.
- busy  out  1  high when the FSM is outside COUNT.

## Operation
- State: boundary register b; live counters miss0/miss1; snapshots s0/s1; epoch counter; move direction; FSM COUNT → DECIDE → {COUNT | FLUSH} → COUNT.
- Reset values:
  - b = NUM_WAYS/2. With NUM_WAYS=8, way_mask_d0=0x0F and way_mask_d1=0xF0.
  - flush_valid=0, flush_way=0, busy=0.
  - All counters are 0. The FSM is in COUNT.
- Miss counting:
  - Always active, in every state.
  - A miss increments the counter selected by req_domain, saturating at 2^CNT_W−1.
  - Hits and cycles with req_valid=0 do not change the counters.
- COUNT:
  - The epoch counter increments every cycle.
  - In the cycle where it equals EPOCH_LEN−1:
    - s0/s1 take the live counter values, including that cycle's miss if one occurs.
    - The live counters and the epoch counter clear.
    - The FSM moves to DECIDE.
  - The epoch counter holds outside COUNT.
- DECIDE lasts one cycle. Comparisons use CNT_W+1 bits, so s+HYST never wraps.
  - If s1 > s0+HYST and b > MIN_WAYS: way b−1 moves to domain 1. flush_way=b−1; go to FLUSH.
  - Else if s0 > s1+HYST and b < NUM_WAYS−MIN_WAYS: way b moves to domain 0. flush_way=b; go to FLUSH.
  - Otherwise return to COUNT; the masks are unchanged.
- FLUSH:
  - flush_valid=1. flush_way is held stable until the handshake.
  - The moving way's bit is cleared in both masks for the whole FLUSH state.
  - On flush_valid && flush_ready:
    - b steps by ±1.
    - The masks recompute from the new b and take effect the next cycle.
    - flush_valid drops the next cycle and the FSM returns to COUNT.
  - flush_ready while flush_valid=0 is ignored.
- Invariants, checked every cycle:
  - way_mask_d0 & way_mask_d1 == 0.
  - Outside FLUSH, way_mask_d0 | way_mask_d1 is all ones.
  - MIN_WAYS ≤ b ≤ NUM_WAYS−MIN_WAYS.
- Reset asserted mid-FLUSH: flush_valid drops asynchronously and b returns to NUM_WAYS/2. A partially flushed way is not reported again.

## Timing
- All outputs are registered.
- Epoch end at COUNT cycle N → DECIDE at N+1 → flush_valid, busy and the cleared mask bit all appear at N+2.
- Handshake at cycle H → new masks and boundary at H+1, flush_valid=0 at H+1.
- Decision latency from the epoch's last cycle to a committed move is 3 cycles minimum.
- A decision with no move: busy is high for exactly the one DECIDE cycle.
- The next epoch's count starts in the first COUNT cycle after returning.

## Test plan
- Reset and idle: deassert reset, no traffic for 1000 cycles.
  - Masks stay 0x0F/0xF0, boundary=4.
  - busy pulses high for one cycle every 257 cycles; flush_valid never rises.
- Domain 1 heavy: 20 domain-1 misses, 0 domain-0 misses in the epoch, flush_ready tied high.
  - 2 cycles after the epoch ends: flush_valid=1, flush_way=3, masks 0x07/0xF0.
  - Next cycle: masks 0x07/0xF8, boundary=3.
- Hysteresis: s1=s0+4 → no move. s1=s0+5 → way moves.
- Floor and ceiling:
  - Repeated domain-1-heavy epochs drive boundary down to 1 and stop there; masks 0x01/0xFE.
  - The symmetric domain-0 case stops at boundary=7.
- Backpressure: hold flush_ready=0 for 10 cycles.
  - flush_valid and flush_way stay stable; the moving bit stays clear in both masks.
  - Misses arriving during this time are counted into the next epoch.
- Reset mid-FLUSH and saturation:
  - Reset during FLUSH → masks 0x0F/0xF0 and flush_valid=0 immediately.
  - With CNT_W=4, 40 misses in one epoch → snapshot is 15.
